seq_mult_digit: RTL and testbench

Parametrised sequential unsigned multiplier that forms a WIDTH×WIDTH product by iterating over DIGIT-bit slices of both operands. Each cycle it multiplies one slice pair, shifts the result and adds it into an accumulator. It generalises the fixed 8×8 nibble-mux multiplier datapath to arbitrary operand/digit widths and adds a start/busy/done handshake. It sits between operand registers and the result/display logic of the multiplier top level.

---
 rtl/seq_mult_digit_pkg.sv | 25 ++
 rtl/seq_mult_digit_digit_sel.sv | 27 ++
 rtl/seq_mult_digit.sv | 147 ++++++++++++++
 tb/tb_seq_mult_digit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_digit_pkg.sv
// Shared definitions for the digit-serial multiplier: FSM states, default geometry
// and helpers that derive the slice count and slice-index width.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DIGIT = 4;

    function automatic int num_slices(input int width, input int digit);
        return width / digit;
    endfunction

    // A single slice still needs a one-bit index so the counters stay legal.
    function automatic int idx_width(input int width, input int digit);
        int n;
        n = width / digit;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_mult_digit_digit_sel.sv
// Slice selector: returns DIGIT-bit slice sel_i of a WIDTH-bit operand
// (the parametrised successor of the fixed nibble mux).
module digit_sel
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIGIT = DEFAULT_DIGIT,
    parameter int IW    = idx_width(WIDTH, DIGIT)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [IW-1:0]    sel_i,
    output logic [DIGIT-1:0] slice_o
);

    localparam int N = num_slices(WIDTH, DIGIT);

    // Explicit compare-per-slice mux so an out-of-range index yields zero.
    always_comb begin
        slice_o = '0;
        for (int k = 0; k < N; k++) begin
            if (sel_i == IW'(k)) begin
                slice_o = data_i[k*DIGIT +: DIGIT];
            end
        end
    end

endmodule

// File: rtl/seq_mult_digit.sv
// Sequential unsigned WIDTH x WIDTH multiplier, one DIGIT x DIGIT slice pair per cycle.
// Optional feature macro: SEQ_MULT_ZERO_SKIP_EN (finish early when an operand is zero).
module seq_mult_digit
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic                 clk,
    input  logic                 reset_a,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dataa,
    input  logic [WIDTH-1:0]     datab,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int N    = num_slices(WIDTH, DIGIT);
    localparam int IW   = idx_width(WIDTH, DIGIT);
    localparam int ACCW = 2 * WIDTH;
    localparam int PPW  = 2 * DIGIT;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    if (WIDTH % DIGIT != 0) begin : g_bad_params
        $error("seq_mult_digit: WIDTH must be a multiple of DIGIT");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [ACCW-1:0]   acc_q, acc_d;
    logic [ACCW-1:0]   product_q, product_d;
    logic [IW-1:0]     i_q, i_d;
    logic [IW-1:0]     j_q, j_d;

    logic [DIGIT-1:0]  aSlice;
    logic [DIGIT-1:0]  bSlice;
    logic [PPW-1:0]    partial;
    logic [ACCW-1:0]   partialShifted;
    logic [ACCW-1:0]   accSum;
    int                shiftAmt;
    logic              zeroSkip;

    digit_sel #(.WIDTH(WIDTH), .DIGIT(DIGIT), .IW(IW)) u_sel_a (
        .data_i  (a_q),
        .sel_i   (i_q),
        .slice_o (aSlice)
    );

    digit_sel #(.WIDTH(WIDTH), .DIGIT(DIGIT), .IW(IW)) u_sel_b (
        .data_i  (b_q),
        .sel_i   (j_q),
        .slice_o (bSlice)
    );

    assign partial        = {{DIGIT{1'b0}}, aSlice} * {{DIGIT{1'b0}}, bSlice};
    assign shiftAmt       = (int'(i_q) + int'(j_q)) * DIGIT;
    assign partialShifted = ACCW'(partial) << shiftAmt;
    assign accSum         = acc_q + partialShifted;

`ifdef SEQ_MULT_ZERO_SKIP_EN
    assign zeroSkip = (a_q == '0) || (b_q == '0);
`else
    assign zeroSkip = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
            i_q       <= '0;
            j_q       <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            i_q       <= i_d;
            j_q       <= j_d;
        end
    end

    // j runs fastest; the (LAST, LAST) pair commits the final sum straight to product.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        product_d = product_q;
        i_d       = i_q;
        j_d       = j_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = dataa;
                    b_d     = datab;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = CALC;
                end
            end

            CALC: begin
                if (zeroSkip) begin
                    product_d = '0;
                    i_d       = '0;
                    j_d       = '0;
                    state_d   = DONE;
                end else begin
                    acc_d = accSum;
                    if (j_q == LAST) begin
                        j_d = '0;
                        if (i_q == LAST) begin
                            product_d = accSum;
                            i_d       = '0;
                            state_d   = DONE;
                        end else begin
                            i_d = i_q + IW'(1);
                        end
                    end else begin
                        j_d = j_q + IW'(1);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign product = product_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_seq_mult_digit.sv
// Scoreboard bench for seq_mult_digit: an 8x8/4 instance and a 16x16/4 instance,
// directed vectors with hand-computed products and completion cycles.
module tb_seq_mult_digit;

`ifdef SEQ_MULT_ZERO_SKIP_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 4;
`endif

    typedef struct {
        logic [31:0] prod;
        int          t0;
        int          doneCyc;
    } exp_t;

    logic        clk;
    logic        reset_a;
    logic        start;
    logic [7:0]  dataa;
    logic [7:0]  datab;
    logic [15:0] product;
    logic        busy;
    logic        done;

    logic        start16;
    logic [15:0] dataa16;
    logic [15:0] datab16;
    logic [31:0] product16;
    logic        busy16;
    logic        done16;

    int   cyc;
    int   testsRun;
    int   testsFailed;
    exp_t sb[$];
    exp_t sb16[$];
    logic [15:0] heldExp;
    logic [31:0] heldExp16;
    logic        prevDone;

    seq_mult_digit #(.WIDTH(8), .DIGIT(4)) dut (
        .clk     (clk),
        .reset_a (reset_a),
        .start   (start),
        .dataa   (dataa),
        .datab   (datab),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    seq_mult_digit #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk     (clk),
        .reset_a (reset_a),
        .start   (start16),
        .dataa   (dataa16),
        .datab   (datab16),
        .product (product16),
        .busy    (busy16),
        .done    (done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic reportFail(input string name, input int actual, input int expected);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    // Waits for the 8-bit unit to be idle, pulses start for one cycle and books the result.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic [15:0] expProd, input int lat);
        exp_t e;
        int   waited;
        waited = 0;
        while (busy !== 1'b0 && waited < 100) begin
            @(posedge clk); #2;
            waited++;
        end
        if (waited >= 100) reportFail("idle_timeout", waited, 0);
        dataa = a;
        datab = b;
        start = 1'b1;
        e.prod    = {16'h0, expProd};
        e.t0      = cyc + 1;
        e.doneCyc = cyc + 1 + lat;
        sb.push_back(e);
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic applyStimulus16(input logic [15:0] a, input logic [15:0] b,
                                   input logic [31:0] expProd, input int lat);
        exp_t e;
        dataa16 = a;
        datab16 = b;
        start16 = 1'b1;
        e.prod    = expProd;
        e.t0      = cyc + 1;
        e.doneCyc = cyc + 1 + lat;
        sb16.push_back(e);
        @(posedge clk); #2;
        start16 = 1'b0;
    endtask

    task automatic waitDrain();
        int waited;
        waited = 0;
        while ((sb.size() != 0 || sb16.size() != 0 || busy !== 1'b0) && waited < 200) begin
            @(posedge clk); #2;
            waited++;
        end
        if (waited >= 200) reportFail("drain_timeout", waited, 0);
    endtask

    // Monitor for the 8-bit unit: done pulse, product, completion cycle, busy and hold.
    always @(negedge clk) begin
        exp_t e;
        logic expBusy;
        if (reset_a) begin
            prevDone = 1'b0;
        end else begin
            expBusy = (sb.size() > 0) && (cyc >= sb[0].t0);
            checkOutput("busy", {63'h0, busy}, {63'h0, expBusy});
            if (done) begin
                if (prevDone) reportFail("done_single_pulse", 2, 1);
                if (sb.size() == 0) begin
                    reportFail("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("product", {48'h0, product}, {32'h0, e.prod});
                    checkOutput("done_cycle", 64'(cyc), 64'(e.doneCyc));
                    heldExp = e.prod[15:0];
                end
            end else begin
                checkOutput("product_hold", {48'h0, product}, {48'h0, heldExp});
                if (sb.size() > 0 && cyc > sb[0].doneCyc) begin
                    e = sb.pop_front();
                    reportFail("done_missing", cyc, e.doneCyc);
                end
            end
            prevDone = done;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset_a) begin
            if (done16) begin
                if (sb16.size() == 0) begin
                    reportFail("unexpected_done16", 1, 0);
                end else begin
                    e = sb16.pop_front();
                    checkOutput("product16", {32'h0, product16}, {32'h0, e.prod});
                    checkOutput("done_cycle16", 64'(cyc), 64'(e.doneCyc));
                    heldExp16 = e.prod;
                end
            end else if (sb16.size() > 0 && cyc > sb16[0].doneCyc) begin
                e = sb16.pop_front();
                reportFail("done_missing16", cyc, e.doneCyc);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        heldExp     = '0;
        heldExp16   = '0;
        prevDone    = 1'b0;
        reset_a     = 1'b1;
        start       = 1'b0;
        dataa       = '0;
        datab       = '0;
        start16     = 1'b0;
        dataa16     = '0;
        datab16     = '0;

        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_product", {48'h0, product}, 64'h0);
        checkOutput("reset_busy", {63'h0, busy}, 64'h0);
        checkOutput("reset_done", {63'h0, done}, 64'h0);
        checkOutput("reset_product16", {32'h0, product16}, 64'h0);
        reset_a = 1'b0;
        @(posedge clk); #2;

        $display("[TB] 16x16 with 4-bit digits");
        applyStimulus16(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16);

        $display("[TB] basic products");
        applyStimulus(8'hF0, 8'hA5, 16'h9AB0, 4);
        applyStimulus(8'hFF, 8'hFF, 16'hFE01, 4);
        applyStimulus(8'h01, 8'h01, 16'h0001, 4);
        applyStimulus(8'h80, 8'h02, 16'h0100, 4);
        applyStimulus(8'h00, 8'h37, 16'h0000, ZERO_LAT);
        applyStimulus(8'h37, 8'h00, 16'h0000, ZERO_LAT);

        $display("[TB] start during CALC is ignored");
        applyStimulus(8'h03, 8'h05, 16'h000F, 4);
        dataa = 8'h12;
        datab = 8'h34;
        start = 1'b1;
        repeat (2) begin
            @(posedge clk); #2;
        end
        start = 1'b0;
        applyStimulus(8'h12, 8'h34, 16'h03A8, 4);
        waitDrain();

        $display("[TB] reset during CALC");
        applyStimulus(8'hF0, 8'hA5, 16'h9AB0, 4);
        applyStimulus(8'hFF, 8'hFF, 16'hFE01, 4);
        @(posedge clk); #2;
        reset_a = 1'b1;
        sb.delete();
        heldExp = '0;
        #1;
        checkOutput("abort_product", {48'h0, product}, 64'h0);
        checkOutput("abort_busy", {63'h0, busy}, 64'h0);
        checkOutput("abort_done", {63'h0, done}, 64'h0);
        @(posedge clk); #2;
        reset_a = 1'b0;
        repeat (8) begin
            @(posedge clk); #2;
        end
        applyStimulus(8'hF0, 8'hA5, 16'h9AB0, 4);
        applyStimulus(8'h0F, 8'h0F, 16'h00E1, 4);
        waitDrain();
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
